// File: rtl/fsb_cycle_ctrl_pkg.sv
// Shared FSB cycle definitions: controller state encoding, cycle-type encodings
// and the byte-enable to bit-mask helper. Also imported by north_bridge.
package fsb_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_REQ   = 3'd2,
        ST_RESP  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_READY = 3'd5
    } fsb_state_e;

    // cycle_type = {W_NR, M_NIO, D_NC}
    localparam int CT_WR   = 2;
    localparam int CT_MEM  = 1;
    localparam int CT_DATA = 0;

    localparam logic [2:0] CYC_IO_RD_DATA  = 3'b001;
    localparam logic [2:0] CYC_MEM_RD_DATA = 3'b011;
    localparam logic [2:0] CYC_IO_WR_DATA  = 3'b101;
    localparam logic [2:0] CYC_MEM_WR_DATA = 3'b111;

    function automatic logic [31:0] nbe_to_mask(input logic [3:0] nbe);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = nbe[b] ? 8'h00 : 8'hFF;
        return m;
    endfunction

endpackage

// File: rtl/fsb_cycle_timer.sv
// Wait-state down-counter and REQ/RESP timeout up-counter for fsb_cycle_ctrl.
module fsb_cycle_timer #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic wait_load,
    input  logic wait_en,
    input  logic to_clr,
    input  logic to_en,
    output logic wait_zero,
    output logic to_expired
);
    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] to_cnt;

    assign wait_zero  = (wait_cnt == '0);
    // Expires on the TIMEOUT-th cycle spent counting, so the FSM never exceeds TIMEOUT cycles.
    assign to_expired = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            wait_cnt <= '0;
        else if (wait_load)
            wait_cnt <= WW'(WAIT_STATES);
        else if (wait_en && !wait_zero)
            wait_cnt <= wait_cnt - WW'(1);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            to_cnt <= '0;
        else if (to_clr)
            to_cnt <= '0;
        else if (to_en && !to_expired)
            to_cnt <= to_cnt + TW'(1);
    end

endmodule

// File: rtl/fsb_cycle_ctrl.sv
// CPU front-side-bus cycle controller: turns FSB address-strobe cycles into
// downstream requests toward north_bridge and returns NRDY / read data.
module fsb_cycle_ctrl
    import fsb_cycle_ctrl_pkg::*;
#(
    parameter int FSB_ADDR_WIDTH = 32,
    parameter int FSB_DATA_WIDTH = 32,
    parameter int WAIT_STATES    = 1,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [FSB_ADDR_WIDTH-1:2] FSB_addr,
    input  logic [FSB_DATA_WIDTH-1:0] FSB_data_i,
    output logic [FSB_DATA_WIDTH-1:0] FSB_data_o,
    input  logic [3:0]                FSB_NBE,
    input  logic                      FSB_W_NR,
    input  logic                      FSB_M_NIO,
    input  logic                      FSB_D_NC,
    input  logic                      FSB_NADS,
    output logic                      FSB_NRDY,
    output logic                      cyc_valid,
    input  logic                      cyc_ready,
    output logic [2:0]                cyc_type,
    output logic [FSB_ADDR_WIDTH-1:2] cyc_addr,
    output logic [FSB_DATA_WIDTH-1:0] cyc_wdata,
    output logic [FSB_DATA_WIDTH-1:0] cyc_mask,
    input  logic                      rsp_valid,
    input  logic [FSB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      bus_err
);
    fsb_state_e state_q, state_d;
    logic wait_load, wait_en, wait_zero, to_clr, to_en, to_expired;
    logic latch_cmd, latch_wdata, cap_rsp, rd_timeout, rd_local, set_err;
    logic is_wr;

    assign is_wr     = cyc_type[CT_WR];
    assign cyc_valid = (state_q == ST_REQ);
    assign FSB_NRDY  = (state_q != ST_READY);

    fsb_cycle_timer #(.WAIT_STATES(WAIT_STATES), .TIMEOUT(TIMEOUT)) u_timer (
        .clk(clk), .nrst(nrst),
        .wait_load(wait_load), .wait_en(wait_en),
        .to_clr(to_clr), .to_en(to_en),
        .wait_zero(wait_zero), .to_expired(to_expired)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        wait_load   = 1'b0;
        wait_en     = 1'b0;
        to_clr      = 1'b0;
        to_en       = 1'b0;
        latch_cmd   = 1'b0;
        latch_wdata = 1'b0;
        cap_rsp     = 1'b0;
        rd_timeout  = 1'b0;
        rd_local    = 1'b0;
        set_err     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!FSB_NADS) begin
                latch_cmd = 1'b1;
                state_d   = ST_ADDR;
            end
            ST_ADDR: begin
                latch_wdata = is_wr;
                // Command cycles and all-bytes-disabled cycles complete locally.
                if (cyc_type[CT_DATA] && cyc_mask != '0) begin
                    to_clr  = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    wait_load = 1'b1;
                    rd_local  = !is_wr;
                    state_d   = ST_WAIT;
                end
            end
            ST_REQ: begin
                to_en = 1'b1;
                if (cyc_ready) begin
                    wait_load = 1'b1;
                    state_d   = is_wr ? ST_WAIT : ST_RESP;
                end else if (to_expired) begin
                    set_err    = 1'b1;
                    rd_timeout = !is_wr;
                    state_d    = ST_READY;
                end
            end
            ST_RESP: begin
                wait_en = 1'b1;
                to_en   = 1'b1;
                if (rsp_valid) begin
                    cap_rsp = 1'b1;
                    state_d = ST_WAIT;
                end else if (to_expired) begin
                    set_err    = 1'b1;
                    rd_timeout = 1'b1;
                    state_d    = ST_READY;
                end
            end
            ST_WAIT: begin
                wait_en = 1'b1;
                if (wait_zero) state_d = ST_READY;
            end
            ST_READY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cyc_addr <= '0;
            cyc_type <= '0;
            cyc_mask <= '0;
        end else if (latch_cmd) begin
            cyc_addr <= FSB_addr;
            cyc_type <= {FSB_W_NR, FSB_M_NIO, FSB_D_NC};
            cyc_mask <= FSB_DATA_WIDTH'(nbe_to_mask(FSB_NBE));
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)            cyc_wdata <= '0;
        else if (latch_wdata) cyc_wdata <= FSB_data_i;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)           FSB_data_o <= '0;
        else if (cap_rsp)    FSB_data_o <= rsp_rdata & cyc_mask;
        else if (rd_timeout) FSB_data_o <= '1;
        else if (rd_local)   FSB_data_o <= '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)        bus_err <= 1'b0;
        else if (set_err) bus_err <= 1'b1;
    end

endmodule
